// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the hardwired control unit:
//     - machine sizes (register count, opcode and register-field widths)
//     - IR field bit positions (opcode, ra, rb, rc)
//     - opcode encodings ld=0 .. not=18
//     - control-FSM state encoding (IDLE, T0..T6, HALT)
//     - classify(): maps an opcode onto its execute-sequence class
//   Optional feature macro: CU_IMM_EN. When it is defined, addi/andi/ori are
//   classified as legal immediate ops. Otherwise they are illegal.
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int NUM_REGS    = 16;
  localparam int OPCODE_W    = 5;
  localparam int REG_FIELD_W = 4;
  localparam int IR_W        = 32;

  localparam int OPC_MSB = 31, OPC_LSB = 27;
  localparam int RA_MSB  = 26, RA_LSB  = 23;
  localparam int RB_MSB  = 22, RB_LSB  = 19;
  localparam int RC_MSB  = 18, RC_LSB  = 15;

  localparam logic [OPCODE_W-1:0] OP_LD   = 5'd0;
  localparam logic [OPCODE_W-1:0] OP_LDI  = 5'd1;
  localparam logic [OPCODE_W-1:0] OP_ST   = 5'd2;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'd3;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'd4;
  localparam logic [OPCODE_W-1:0] OP_SHR  = 5'd5;
  localparam logic [OPCODE_W-1:0] OP_SHRA = 5'd6;
  localparam logic [OPCODE_W-1:0] OP_SHL  = 5'd7;
  localparam logic [OPCODE_W-1:0] OP_ROR  = 5'd8;
  localparam logic [OPCODE_W-1:0] OP_ROL  = 5'd9;
  localparam logic [OPCODE_W-1:0] OP_AND  = 5'd10;
  localparam logic [OPCODE_W-1:0] OP_OR   = 5'd11;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 5'd12;
  localparam logic [OPCODE_W-1:0] OP_ANDI = 5'd13;
  localparam logic [OPCODE_W-1:0] OP_ORI  = 5'd14;
  localparam logic [OPCODE_W-1:0] OP_MUL  = 5'd15;
  localparam logic [OPCODE_W-1:0] OP_DIV  = 5'd16;
  localparam logic [OPCODE_W-1:0] OP_NEG  = 5'd17;
  localparam logic [OPCODE_W-1:0] OP_NOT  = 5'd18;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  // Execute-sequence class of an opcode. The unary, imm and muldiv fields
  // only carry meaning when legal is set.
  typedef struct packed {
    logic legal;
    logic unary;   // neg/not: single source rb, no Y load
    logic imm;     // addi/andi/ori: second operand is the sign-extended constant
    logic muldiv;  // result is split over LO (T5) and HI (T6)
  } op_class_t;

  function automatic op_class_t classify(input logic [OPCODE_W-1:0] op);
    op_class_t c;
    c = '0;
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR: c.legal = 1'b1;
      OP_MUL, OP_DIV: begin
        c.legal  = 1'b1;
        c.muldiv = 1'b1;
      end
      OP_NEG, OP_NOT: begin
        c.legal = 1'b1;
        c.unary = 1'b1;
      end
`ifdef CU_IMM_EN
      OP_ADDI, OP_ANDI, OP_ORI: begin
        c.legal = 1'b1;
        c.imm   = 1'b1;
      end
`else
      OP_ADDI, OP_ANDI, OP_ORI: c = '0;
`endif
      // Memory instructions are not sequenced by this unit.
      OP_LD, OP_LDI, OP_ST: c = '0;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// ---------------------------------------------------------------------------
// reg_select_decoder
//   Binary-to-one-hot register select with enable.
//   Ports:
//     en      in   1        when 0 the output is all zeros
//     sel     in   SEL_W    register index
//     onehot  out  NUM_OUT  bit [sel] set when en = 1
// ---------------------------------------------------------------------------
module reg_select_decoder #(
  parameter int SEL_W   = 4,
  parameter int NUM_OUT = 16
) (
  input  logic               en,
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//   Hardwired control FSM for the datapath: fetch T0-T2, decode at T3,
//   execute T3-T6. Outputs are decoded from the registered state and the IR
//   fields, except the T1 PC write, which qualifies on mem_ready.
//   Optional feature macro: CU_IMM_EN enables addi/andi/ori and c_sign_out.
//   Ports:
//     clk, clr          clock (rising edge) / asynchronous active-low reset
//     run               start or continue fetching; sampled in IDLE and at
//                       the end of an instruction
//     ir                instruction register contents
//     mem_ready         memory read data valid this cycle
//     pc_out, zlo_out, zhi_out, mdr_out            bus drive selects
//     mar/pc/mdr/ir/y/z/lo/hi_enable               register loads
//     read, pc_increment, c_sign_out               memory / ALU controls
//     op_code           ALU operation, nonzero only in T4
//     r_enable, r_out   one-hot general-register load / bus drive
//     instr_done        one-cycle pulse in the final execute state
//     illegal           sticky, set on entry to HALT
// ---------------------------------------------------------------------------
module control_unit
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                clr,
  input  logic                run,
  input  logic [IR_W-1:0]     ir,
  input  logic                mem_ready,
  output logic                pc_out,
  output logic                zlo_out,
  output logic                zhi_out,
  output logic                mdr_out,
  output logic                mar_enable,
  output logic                pc_enable,
  output logic                mdr_enable,
  output logic                ir_enable,
  output logic                y_enable,
  output logic                z_enable,
  output logic                lo_enable,
  output logic                hi_enable,
  output logic                read,
  output logic                pc_increment,
  output logic                c_sign_out,
  output logic [OPCODE_W-1:0] op_code,
  output logic [NUM_REGS-1:0] r_enable,
  output logic [NUM_REGS-1:0] r_out,
  output logic                instr_done,
  output logic                illegal
);

  state_t                 state_q, state_d;
  logic                   illegal_q;
  logic [OPCODE_W-1:0]    opcode;
  logic [REG_FIELD_W-1:0] ra, rb, rc;
  op_class_t              cls;
  logic                   rout_en, renable_en;
  logic [REG_FIELD_W-1:0] rout_sel;
  logic                   unused_ir;

  assign opcode = ir[OPC_MSB:OPC_LSB];
  assign ra     = ir[RA_MSB:RA_LSB];
  assign rb     = ir[RB_MSB:RB_LSB];
  assign rc     = ir[RC_MSB:RC_LSB];
  assign cls    = classify(opcode);
  // The low constant bits belong to the datapath's sign extender.
  assign unused_ir = ^ir[RC_LSB-1:0];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_T3 && !cls.legal) illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (mem_ready) state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3:   state_d = cls.legal ? S_T4 : S_HALT;
      S_T4:   state_d = S_T5;
      S_T5: begin
        if (cls.muldiv) state_d = S_T6;
        else            state_d = run ? S_T0 : S_IDLE;
      end
      S_T6:   state_d = run ? S_T0 : S_IDLE;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_out       = 1'b0;
    zlo_out      = 1'b0;
    zhi_out      = 1'b0;
    mdr_out      = 1'b0;
    mar_enable   = 1'b0;
    pc_enable    = 1'b0;
    mdr_enable   = 1'b0;
    ir_enable    = 1'b0;
    y_enable     = 1'b0;
    z_enable     = 1'b0;
    lo_enable    = 1'b0;
    hi_enable    = 1'b0;
    read         = 1'b0;
    pc_increment = 1'b0;
    op_code      = '0;
    instr_done   = 1'b0;
    rout_en      = 1'b0;
    rout_sel     = rb;
    renable_en   = 1'b0;
    case (state_q)
      S_T0: begin
        pc_out       = 1'b1;
        mar_enable   = 1'b1;
        pc_increment = 1'b1;
        z_enable     = 1'b1;
      end
      S_T1: begin
        read       = 1'b1;
        mdr_enable = 1'b1;
        // PC+1 sits in Z since T0; writing it only on the ready cycle keeps
        // the PC load to exactly one per fetch regardless of wait states.
        if (mem_ready) begin
          zlo_out   = 1'b1;
          pc_enable = 1'b1;
        end
      end
      S_T2: begin
        mdr_out   = 1'b1;
        ir_enable = 1'b1;
      end
      S_T3: begin
        // An illegal opcode heads straight to HALT with nothing driven.
        if (cls.legal) begin
          rout_en  = 1'b1;
          y_enable = !cls.unary;
        end
      end
      S_T4: begin
        op_code  = opcode;
        z_enable = 1'b1;
        // Immediate ops take their second operand from the sign extender.
        rout_en  = !cls.imm;
        rout_sel = cls.unary ? rb : rc;
      end
      S_T5: begin
        zlo_out = 1'b1;
        if (cls.muldiv) begin
          lo_enable = 1'b1;
        end else begin
          renable_en = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_T6: begin
        zhi_out    = 1'b1;
        hi_enable  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef CU_IMM_EN
  assign c_sign_out = (state_q == S_T4) && cls.imm;
`else
  assign c_sign_out = 1'b0;
`endif

  reg_select_decoder #(
    .SEL_W   (REG_FIELD_W),
    .NUM_OUT (NUM_REGS)
  ) u_rout_dec (
    .en     (rout_en),
    .sel    (rout_sel),
    .onehot (r_out)
  );

  reg_select_decoder #(
    .SEL_W   (REG_FIELD_W),
    .NUM_OUT (NUM_REGS)
  ) u_renable_dec (
    .en     (renable_en),
    .sel    (ra),
    .onehot (r_enable)
  );

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
//   Scoreboard bench for control_unit. The driver walks each instruction
//   through its fetch/execute timeline, pushing the expected output vector
//   for every cycle; the monitor pops one entry per cycle on the falling
//   edge and compares. Honours CU_IMM_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_control_unit;

`ifdef CU_IMM_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  typedef struct packed {
    logic        pc_out, zlo_out, zhi_out, mdr_out;
    logic        mar_enable, pc_enable, mdr_enable, ir_enable;
    logic        y_enable, z_enable, lo_enable, hi_enable;
    logic        read, pc_increment, c_sign_out;
    logic [4:0]  op_code;
    logic [15:0] r_enable;
    logic [15:0] r_out;
    logic        instr_done, illegal;
  } outs_t;

  typedef struct {
    outs_t exp;
    bit    care;
    string tag;
  } sb_entry_t;

  logic        clk = 1'b0;
  logic        clr, run, mem_ready;
  logic [31:0] ir;
  logic        pc_out, zlo_out, zhi_out, mdr_out;
  logic        mar_enable, pc_enable, mdr_enable, ir_enable;
  logic        y_enable, z_enable, lo_enable, hi_enable;
  logic        read, pc_increment, c_sign_out;
  logic [4:0]  op_code;
  logic [15:0] r_enable, r_out;
  logic        instr_done, illegal;
  outs_t       act;

  sb_entry_t sb_q[$];
  int        checks = 0;
  int        failures = 0;
  bit        in_idle = 1'b0;
  bit        halted = 1'b0;
  logic      exp_illegal = 1'b0;
  int        legal_ops[$];

  control_unit dut (
    .clk(clk), .clr(clr), .run(run), .ir(ir), .mem_ready(mem_ready),
    .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .mdr_out(mdr_out),
    .mar_enable(mar_enable), .pc_enable(pc_enable), .mdr_enable(mdr_enable),
    .ir_enable(ir_enable), .y_enable(y_enable), .z_enable(z_enable),
    .lo_enable(lo_enable), .hi_enable(hi_enable), .read(read),
    .pc_increment(pc_increment), .c_sign_out(c_sign_out), .op_code(op_code),
    .r_enable(r_enable), .r_out(r_out), .instr_done(instr_done), .illegal(illegal)
  );

  assign act = {pc_out, zlo_out, zhi_out, mdr_out, mar_enable, pc_enable, mdr_enable,
                ir_enable, y_enable, z_enable, lo_enable, hi_enable, read, pc_increment,
                c_sign_out, op_code, r_enable, r_out, instr_done, illegal};

  always #5 clk = ~clk;

  task automatic check(input string name, input outs_t got, input outs_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, got, want);
    end
  endtask

  // ---- reference model helpers -------------------------------------------
  function automatic bit op_legal(input int op);
    return (op >= 3 && op <= 11) || (op >= 15 && op <= 18) ||
           (IMM_EN && op >= 12 && op <= 14);
  endfunction

  function automatic logic rbit();
    return $urandom_range(0, 1) != 0;
  endfunction

  function automatic logic [31:0] make_ir(input int op, input int ra, input int rb, input int rc);
    logic [31:0] v;
    v        = $urandom;
    v[31:27] = op[4:0];
    v[26:23] = ra[3:0];
    v[22:19] = rb[3:0];
    v[18:15] = rc[3:0];
    return v;
  endfunction

  // One clock cycle: drive inputs, record expectation, advance to posedge+1.
  task automatic cyc(input outs_t e, input bit care, input logic rn, input logic mr,
                     input logic [31:0] iv, input string tag);
    sb_entry_t ent;
    run       = rn;
    mem_ready = mr;
    ir        = iv;
    ent.exp   = e;
    ent.care  = care;
    ent.tag   = tag;
    sb_q.push_back(ent);
    @(posedge clk);
    #1;
  endtask

  // Present one cycle's expectation, then pull clr low mid-cycle and require
  // every output (illegal included) to drop at once. Release one edge later.
  task automatic push_and_reset(input outs_t e, input logic [31:0] iv, input string tag);
    sb_entry_t ent;
    outs_t     zero;
    zero      = '0;
    run       = rbit();
    mem_ready = rbit();
    ir        = iv;
    ent.exp   = e;
    ent.care  = 1'b1;
    ent.tag   = tag;
    sb_q.push_back(ent);
    #5;
    clr = 1'b0;
    #1;
    check({tag, "_async_reset"}, act, zero);
    @(posedge clk);
    #1;
    clr         = 1'b1;
    run         = 1'b1;
    in_idle     = 1'b1;
    halted      = 1'b0;
    exp_illegal = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    outs_t base;
    base = '0;
    if (in_idle)
      for (int i = 0; i < n; i++) cyc(base, 1'b1, 1'b0, rbit(), $urandom, "idle");
  endtask

  task automatic exec_instr(input logic [31:0] iv, input int nwait, input bit run_next,
                            input bit abort_t4, input string name);
    outs_t       base, e;
    int          op, ra, rb, rc;
    bit          unary, imm, muldiv;
    logic [31:0] junk;
    op     = int'(iv[31:27]);
    ra     = int'(iv[26:23]);
    rb     = int'(iv[22:19]);
    rc     = int'(iv[18:15]);
    unary  = (op == 17 || op == 18);
    imm    = (op >= 12 && op <= 14);
    muldiv = (op == 15 || op == 16);
    junk   = $urandom;
    base   = '0;
    base.illegal = exp_illegal;

    if (in_idle) cyc(base, 1'b1, 1'b1, rbit(), junk, {name, "_idle_start"});
    in_idle = 1'b0;

    e = base; e.pc_out = 1; e.mar_enable = 1; e.pc_increment = 1; e.z_enable = 1;
    cyc(e, 1'b1, rbit(), rbit(), junk, {name, "_T0"});
    for (int w = 0; w < nwait; w++) begin
      e = base; e.read = 1; e.mdr_enable = 1;
      cyc(e, 1'b1, rbit(), 1'b0, junk, $sformatf("%s_T1wait%0d", name, w));
    end
    e = base; e.read = 1; e.mdr_enable = 1; e.zlo_out = 1; e.pc_enable = 1;
    cyc(e, 1'b1, rbit(), 1'b1, junk, {name, "_T1ready"});
    e = base; e.mdr_out = 1; e.ir_enable = 1;
    cyc(e, 1'b1, rbit(), rbit(), junk, {name, "_T2"});

    if (!op_legal(op)) begin
      cyc(base, 1'b0, rbit(), rbit(), iv, {name, "_T3_illegal"});
      exp_illegal = 1'b1;
      halted      = 1'b1;
      return;
    end

    e = base; e.r_out = 16'h1 << rb; e.y_enable = !unary;
    cyc(e, 1'b1, rbit(), rbit(), iv, {name, "_T3"});

    e = base; e.op_code = op[4:0]; e.z_enable = 1;
    if (imm) e.c_sign_out = 1;
    else     e.r_out = 16'h1 << (unary ? rb : rc);
    if (abort_t4) begin
      push_and_reset(e, iv, {name, "_T4"});
      return;
    end
    cyc(e, 1'b1, rbit(), rbit(), iv, {name, "_T4"});

    if (muldiv) begin
      e = base; e.zlo_out = 1; e.lo_enable = 1;
      cyc(e, 1'b1, rbit(), rbit(), iv, {name, "_T5"});
      e = base; e.zhi_out = 1; e.hi_enable = 1; e.instr_done = 1;
      cyc(e, 1'b1, run_next, rbit(), iv, {name, "_T6"});
    end else begin
      e = base; e.zlo_out = 1; e.r_enable = 16'h1 << ra; e.instr_done = 1;
      cyc(e, 1'b1, run_next, rbit(), iv, {name, "_T5"});
    end
    in_idle = !run_next;
  endtask

  // HALT must hold every output low with illegal set, whatever run does,
  // until clr is pulsed.
  task automatic recover(input string name);
    outs_t h;
    h = '0;
    h.illegal = 1'b1;
    if (halted) begin
      for (int i = 0; i < 5; i++)
        cyc(h, 1'b1, rbit(), rbit(), $urandom, $sformatf("%s_halt%0d", name, i));
      push_and_reset(h, $urandom, {name, "_halt_clr"});
    end
  endtask

  // ---- monitor ------------------------------------------------------------
  initial begin
    sb_entry_t ent;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        ent = sb_q.pop_front();
        if (ent.care) check(ent.tag, act, ent.exp);
      end
    end
  end

  // ---- watchdog -----------------------------------------------------------
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---- stimulus -----------------------------------------------------------
  initial begin
    outs_t zero;
    int    op;
    zero      = '0;
    clr       = 1'b1;
    run       = 1'b0;
    mem_ready = 1'b0;
    ir        = '0;
    for (int o = 0; o < 32; o++) if (op_legal(o)) legal_ops.push_back(o);

    #2 clr = 1'b0;
    #1 check("reset_initial", act, zero);
    @(posedge clk);
    #1;
    clr     = 1'b1;
    in_idle = 1'b1;

    idle_cycles(3);
    exec_instr(32'h2891_8000,        0, 1'b1, 1'b0, "shr_r1_r2_r3");
    exec_instr(make_ir(3, 9, 10, 11),  3, 1'b1, 1'b0, "add_wait3");
    exec_instr(make_ir(15, 0, 4, 5),   1, 1'b1, 1'b0, "mul_r0_r4_r5");
    exec_instr(make_ir(17, 6, 7, 8),   0, 1'b1, 1'b0, "neg");
    exec_instr(make_ir(4, 3, 3, 3),    0, 1'b1, 1'b0, "sub_same_regs");
    exec_instr(make_ir(16, 15, 14, 13), 2, 1'b0, 1'b0, "div_then_idle");
    idle_cycles(2);

    for (int i = 0; i < 40; i++) begin
      op = legal_ops[$urandom_range(0, legal_ops.size() - 1)];
      exec_instr(make_ir(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3) != 0, 1'b0,
                 $sformatf("rand%0d_op%0d", i, op));
      idle_cycles($urandom_range(0, 2));
    end

    exec_instr(make_ir(10, 1, 2, 3), 1, 1'b1, 1'b1, "and_reset_midT4");
    exec_instr({5'd12, 4'd1, 4'd2, 19'h7FFFF}, 0, 1'b1, 1'b0, "addi_r1_r2_m1");
    recover("addi");
    exec_instr({5'b11111, 27'h5A5A5A5}, 1, 1'b1, 1'b0, "op31");
    recover("op31");
    exec_instr(make_ir(0, 1, 2, 3), 0, 1'b1, 1'b0, "ld");
    recover("ld");
    exec_instr(make_ir(18, 4, 5, 6), 0, 1'b0, 1'b0, "not_final");
    idle_cycles(2);

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
